// File: rtl/statled_seq.sv
// Status sequencer: latches event lines into pending flags and shows them round-robin on `status`.
// Define STATLED_SEQ_STICKY_EN to keep flags set after display (only clr/reset clear them).
module statled_seq #(
  parameter int unsigned FRAME_CLKS  = 1000,
  parameter int unsigned HOLD_FRAMES = 2,
  parameter int unsigned GAP_FRAMES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] evt,
  input  logic       clr,
  output logic [3:0] status,
  output logic       busy,
  output logic [5:0] pend
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [31:0] FRAME_LAST = 32'(FRAME_CLKS - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP_FRAMES - 1);

  state_t      state, state_nxt;
  logic [5:0]  sync1, sync2;
  logic [31:0] fcnt;
  logic        tick;
  logic [2:0]  last, last_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [7:0]  gcnt, gcnt_nxt;
  logic        rel;
  logic [5:0]  rel_mask, avail;
  logic [3:0]  nxt;
  logic [3:0]  status_nxt;
  logic        busy_nxt;

  // Scan last+1 .. last+6 (mod 6); the last write in the loop is the nearest candidate.
  function automatic logic [3:0] next_code(input logic [5:0] flags, input logic [2:0] from);
    logic [3:0] r;
    logic [2:0] p;
    r = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      p = 3'((32'(from) + 6 - k) % 6);
      if (flags[p]) r = {1'b1, p};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= evt;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fcnt <= '0;
    else if (tick) fcnt <= '0;
    else           fcnt <= fcnt + 32'd1;
  end

  assign tick = (fcnt == FRAME_LAST);
  assign rel  = (state == SHOW) && tick && (hcnt == HOLD_LAST);

`ifdef STATLED_SEQ_STICKY_EN
  assign rel_mask = '0;
`else
  assign rel_mask = rel ? (6'b000001 << last) : '0;
`endif

  // The code being released is excluded from the scan so a zero-gap build does not re-show it.
  assign avail = pend & ~rel_mask;
  assign nxt   = next_code(avail, last);

  // A synchronized set always wins over clr or release in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~(clr ? 6'b111111 : rel_mask)) | sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 3'd5;
      hcnt   <= '0;
      gcnt   <= '0;
      status <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      hcnt   <= hcnt_nxt;
      gcnt   <= gcnt_nxt;
      status <= status_nxt;
      busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hcnt_nxt  = hcnt;
    gcnt_nxt  = gcnt;
    unique case (state)
      IDLE: begin
        if (tick && nxt[3]) begin
          state_nxt = SHOW;
          last_nxt  = nxt[2:0];
          hcnt_nxt  = '0;
        end
      end
      SHOW: begin
        if (tick) begin
          hcnt_nxt = hcnt + 8'd1;
          if (rel) begin
            if (GAP_FRAMES > 0) begin
              state_nxt = GAP;
              gcnt_nxt  = '0;
            end else if (nxt[3]) begin
              last_nxt = nxt[2:0];
              hcnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          gcnt_nxt = gcnt + 8'd1;
          if (gcnt == GAP_LAST) begin
            if (nxt[3]) begin
              state_nxt = SHOW;
              last_nxt  = nxt[2:0];
              hcnt_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      last_nxt  = last;
      hcnt_nxt  = '0;
      gcnt_nxt  = '0;
    end
  end

  always_comb begin
    status_nxt = '0;
    busy_nxt   = (state_nxt != IDLE);
    case (state_nxt)
      SHOW:    status_nxt = {1'b0, last_nxt} + 4'd1;
      GAP:     status_nxt = 4'hF;
      default: status_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_statled_seq.sv
// Directed bench for statled_seq with FRAME_CLKS=8, HOLD_FRAMES=2, GAP_FRAMES=1.
module tb_statled_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] evt = '0;
  logic       clr = 1'b0;
  logic [3:0] status;
  logic       busy;
  logic [5:0] pend;

  int errors = 0;
  int checks = 0;

  statled_seq #(.FRAME_CLKS(8), .HOLD_FRAMES(2), .GAP_FRAMES(1)) dut (
    .clk(clk), .rst_n(rst_n), .evt(evt), .clr(clr),
    .status(status), .busy(busy), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    evt   = '0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_evt(input logic [5:0] m);
    @(negedge clk);
    evt = m;
    @(negedge clk);
    evt = '0;
  endtask

  task automatic wait_status(input string tag, input logic [3:0] code);
    int w = 0;
    while (status !== code && w < 300) begin
      @(negedge clk);
      w++;
    end
    check({tag, " seen"}, status, code);
  endtask

  // Wait for a code to appear, then measure how many clocks it stays.
  task automatic expect_phase(input string tag, input logic [3:0] code, input int clks);
    int n = 0;
    wait_status(tag, code);
    while (status === code && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " len"}, n, clks);
  endtask

  initial begin
    int bad;

    // Reset state and asynchronous reset in SHOW
    apply_reset();
    check("rst status", status, 4'h0);
    check("rst pend", pend, 6'b000000);
    check("rst busy", busy, 1'b0);
    pulse_evt(6'b001000);
    wait_status("t1 show4", 4'h4);
    repeat (5) @(negedge clk);
    check("t1 busy in show", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst status", status, 4'h0);
    check("async rst pend", pend, 6'b000000);
    check("async rst busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (status !== 4'h0) bad++;
    end
    check("idle hold 100", bad, 0);

`ifndef STATLED_SEQ_STICKY_EN
    // Single event: latency then 3 / F / 0
    apply_reset();
    @(negedge clk);
    evt = 6'b000100;
    @(negedge clk);
    evt = '0;
    @(posedge clk);
    #1 check("pend at 2 clk", pend, 6'b000000);
    @(posedge clk);
    #1 check("pend at 3 clk", pend, 6'b000100);
    expect_phase("t2 code3", 4'h3, 16);
    expect_phase("t2 gap", 4'hF, 8);
    check("t2 end status", status, 4'h0);
    check("t2 end busy", busy, 1'b0);
    check("t2 end pend", pend, 6'b000000);

    // Simultaneous events
    apply_reset();
    pulse_evt(6'b010001);
    expect_phase("t3 code1", 4'h1, 16);
    expect_phase("t3 gap1", 4'hF, 8);
    expect_phase("t3 code5", 4'h5, 16);
    expect_phase("t3 gap2", 4'hF, 8);
    check("t3 end status", status, 4'h0);
    check("t3 end pend", pend, 6'b000000);

    // Round-robin with held events
    apply_reset();
    @(negedge clk);
    evt = 6'b100010;
    expect_phase("t4 code2 a", 4'h2, 16);
    expect_phase("t4 gap a", 4'hF, 8);
    expect_phase("t4 code6 a", 4'h6, 16);
    expect_phase("t4 gap b", 4'hF, 8);
    expect_phase("t4 code2 b", 4'h2, 16);
    expect_phase("t4 gap c", 4'hF, 8);
    expect_phase("t4 code6 b", 4'h6, 16);
    evt = '0;
`else
    // Sticky: one pulse repeats until clr
    apply_reset();
    pulse_evt(6'b001000);
    for (int i = 0; i < 5; i++) begin
      expect_phase("t6 code4", 4'h4, 16);
      expect_phase("t6 gap", 4'hF, 8);
      check("t6 pend held", pend, 6'b001000);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t6 clr status", status, 4'h0);
    check("t6 clr pend", pend, 6'b000000);
    check("t6 clr busy", busy, 1'b0);
`endif

    // clr during SHOW, then clr colliding with a sync-set
    apply_reset();
    pulse_evt(6'b001000);
    wait_status("t5 show4", 4'h4);
    repeat (3) @(negedge clk);
    check("t5 busy before clr", busy, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5 clr status", status, 4'h0);
    check("t5 clr busy", busy, 1'b0);
    check("t5 clr pend", pend, 6'b000000);
    @(negedge clk);
    evt = 6'b000001;
    @(negedge clk);
    evt = '0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5 set beats clr", pend, 6'b000001);
    expect_phase("t5 code1", 4'h1, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/statled_seq.md
# statled_seq

Status sequencer feeding the 4-bit `status` input of the status LED driver. Captures up to six asynchronous event lines into pending flags and presents one pending code at a time, each for a fixed number of display frames. Codes are separated by a dark gap and visited round-robin. With nothing pending it outputs code 0, the default 50/50 blink.

## Interface

Parameters:
- `FRAME_CLKS`, default 1000: clocks per display frame; minimum 2.
- `HOLD_FRAMES`, default 2: frames each code is shown; range 1..255.
- `GAP_FRAMES`, default 1: dark frames after each code; range 0..255.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `evt`  in  6  event lines, asynchronous; `evt[i]` requests code i+1
- `clr`  in  1  synchronous clear of all pending flags
- `status`  out  4  code to LED driver, registered
- `busy`  out  1  high when state ≠ IDLE
- `pend`  out  6  pending flags, registered

## Operation

- **Synchronizer:** each `evt` bit passes through two flops. Any synchronized high cycle sets `pend[i]`, so the input is level-sampled.
- **Frame counter:** `fcnt` is a free-running 32-bit count 0..FRAME_CLKS-1.
  - `tick` = (`fcnt` == FRAME_CLKS-1), after which `fcnt` wraps to 0.
  - State changes occur only on `tick`, except for `clr`.
- **Pointer:** `last` is a 3-bit index of the most recently shown code.
  - The next code is the first set `pend` bit scanning `last`+1, `last`+2, …, wrapping 5→0.
  - If `last` itself is the only pending bit, it is selected.
- **FSM:**
  - **IDLE** (`status`=0): on `tick` with `pend`≠0, select the next code, set `last`=idx and `status`=idx+1, clear `hcnt`, go to SHOW.
  - **SHOW**: on each `tick`, increment `hcnt`.
    - On the tick where `hcnt`==HOLD_FRAMES-1, release the code per Configuration.
    - Then, if GAP_FRAMES>0: go to GAP with `status`=4'hF (undefined code, LED dark) and clear `gcnt`.
    - Otherwise, select the next code directly; if none is pending, go to IDLE with `status`=0.
  - **GAP**: on each `tick`, increment `gcnt`. When `gcnt`==GAP_FRAMES-1: if any flag is pending, go to SHOW with the next code; otherwise go to IDLE with `status`=0.
- **`clr`:**
  - Clears all `pend` bits, forces IDLE, sets `status`=0 and clears `hcnt`/`gcnt` in the next cycle.
  - Does not reset `fcnt` or `last`.
- **Set/clear collisions:** a set always wins over any clear (`clr` or release) in the same cycle; events are never lost.
- **Counter widths:** `hcnt` and `gcnt` are 8-bit.

## Timing

- Reset values: `status`=0, `pend`=0, `busy`=0, state IDLE, `fcnt`=0, `hcnt`=0, `gcnt`=0, `last`=5 (first scan starts at code 1), synchronizer flops 0.
- `evt` rising to `pend` visible: 3 clocks (2 sync flops + `pend` register).
- `pend` to `status` change: on the first `tick` after `pend` sets; `status` updates the clock after `tick`.
- Code dwell: exactly HOLD_FRAMES×FRAME_CLKS clocks. Gap dwell: GAP_FRAMES×FRAME_CLKS clocks.
- `busy` is registered and changes in the same cycle as `status`.
- No alignment to the LED driver's internal frame is guaranteed. Integrators set FRAME_CLKS equal to or a multiple of the driver frame length.

## Configuration

- Macro `STATLED_SEQ_STICKY_EN`.
- **Undefined (default):** at release, `pend[last]` clears, unless it is re-set that cycle. Each event is shown once per assertion.
- **Defined:** release does not clear `pend`; only `clr` or reset clears flags. Pending codes repeat round-robin indefinitely.

## Test plan

Bench parameters: FRAME_CLKS=8, HOLD_FRAMES=2, GAP_FRAMES=1.

1. **Reset:** assert `rst_n`=0 mid-SHOW → immediately `status`=0, `pend`=0, `busy`=0. Release; with no events, `status` stays 0 for 100 clocks.
2. **Single event:** 1-cycle pulse on `evt[2]` → `pend`=6'b000100 within 3 clocks. After the next tick, `status`=3 for 16 clocks, then 4'hF for 8 clocks, then 0 with `busy`=0. Non-sticky build: `pend`=0.
3. **Simultaneous events:** pulse `evt[0]` and `evt[4]` in the same cycle → `status` sequence 1 (16 clk), F (8), 5 (16), F (8), 0.
4. **Round-robin:** hold `evt[1]` and `evt[5]` high continuously → `status` alternates 2, F, 6, F, 2, …; no code is shown twice in a row.
5. **clr:** `clr` during SHOW of code 4 → next cycle `status`=0, `busy`=0, `pend`=0. `clr` in the same cycle as an `evt[0]` sync-set → `pend[0]`=1 remains.
6. **Sticky build:** with `STATLED_SEQ_STICKY_EN` defined, pulse `evt[3]` once → `status` cycles 4, F, 4, F, … for ≥5 periods until `clr`, then 0.
